// File: rtl/bus_usart_bridge.sv
// -----------------------------------------------------------------------------
// bus_usart_bridge
//
// Buffered bridge from the Computie bus write path to the usart_ctrl
// transmitter. Each bus write cycle contributes exactly one data beat. The beat
// is zero-extended to a byte and queued in a FIFO. A send state machine drains
// the FIFO into usart_ctrl with a write-strobe/busy handshake. A sticky flag
// records writes that were dropped because the FIFO was full.
//
// Parameters
//   BITWIDTH   width of the bus data beat (1..8)
//   DEPTH      FIFO entries (power of two, >= 2)
//   USART_CMD  command code presented with every byte
//
// Ports
//   clk             system clock, rising edge
//   reset_n         synchronous active-low reset
//   read_write      bus direction; 0 = write cycle
//   from_bus        demuxed bus data beat
//   usart_busy      usart_ctrl is transmitting
//   clear_overflow  single-cycle pulse that clears overflow
//   usart_write     single-cycle transmit strobe
//   usart_cmd       command code to usart_ctrl
//   usart_data      byte to usart_ctrl
//   fifo_count      entries currently queued
//   overflow        sticky: a write was dropped on a full FIFO
// -----------------------------------------------------------------------------
module bus_usart_bridge #(
    parameter int         BITWIDTH  = 2,
    parameter int         DEPTH     = 8,
    parameter logic [2:0] USART_CMD = 3'd1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     read_write,
    input  logic [BITWIDTH-1:0]      from_bus,
    input  logic                     usart_busy,
    input  logic                     clear_overflow,
    output logic                     usart_write,
    output logic [2:0]               usart_cmd,
    output logic [7:0]               usart_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            rw_q;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [1:0]      tcnt;

    logic            push_req;
    logic            push_ok;
    logic            pop;
    logic            tcnt_clr;
    logic            tcnt_inc;

    // One push per write cycle: only the first low sample of read_write counts.
    assign push_req = rw_q & ~read_write;

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok  = push_req & ((fifo_count < CW'(DEPTH)) | pop);

    // -------------------------------------------------------------------------
    // Send FSM: next state and control strobes
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before the case so no
        // path can leave one unassigned and infer a latch.
        state_next = state;
        pop        = 1'b0;
        tcnt_clr   = 1'b0;
        tcnt_inc   = 1'b0;

        case (state)
            S_IDLE: begin
                if (fifo_count != '0 && !usart_busy) begin
                    pop        = 1'b1;
                    state_next = S_STROBE;
                end
            end
            S_STROBE: begin
                tcnt_clr   = 1'b1;
                state_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // Give usart_ctrl four cycles to raise busy; if it never does,
                // assume the strobe was consumed and move on.
                if (usart_busy) begin
                    state_next = S_WAIT_DONE;
                end else if (tcnt == 2'd3) begin
                    state_next = S_IDLE;
                end else begin
                    tcnt_inc = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!usart_busy) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every register
        // samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Write detect. rw_q follows the bus even while reset is asserted, so a
    // write cycle already in progress at reset release is not seen as a new
    // 1->0 transition. With the bus idle during reset it holds 1.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        rw_q <= read_write;
    end

    // -------------------------------------------------------------------------
    // FIFO storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; entries are only ever read after
    // being written, and the pointers/count carry all the reset state.
    always_ff @(posedge clk) begin
        if (reset_n && push_ok) begin
            mem[wr_ptr] <= 8'(from_bus);
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, count, overflow, transmit registers, timeout counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            overflow    <= 1'b0;
            usart_write <= 1'b0;
            usart_cmd   <= 3'd0;
            usart_data  <= 8'd0;
            tcnt        <= 2'd0;
        end else begin
            usart_write <= pop;

            if (pop) begin
                usart_data <= mem[rd_ptr];
                usart_cmd  <= USART_CMD;
                rd_ptr     <= rd_ptr + AW'(1);
            end

            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase

            // A drop in the same cycle as a clear leaves the flag set.
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end

            if (tcnt_clr) begin
                tcnt <= 2'd0;
            end else if (tcnt_inc) begin
                tcnt <= tcnt + 2'd1;
            end
        end
    end

endmodule
